// File: rtl/ex_mem_stage.sv
// Execute-to-memory boundary: resolves branches/jumps combinationally from the ALU flags,
// registers the EX/MEM pipeline state with stall/bubble control, and counts branch events.
module ex_mem_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             Valid_i,
  input  logic             Stall_i,
  input  logic             Flush_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic [2:0]       Funct3_i,
  input  logic [2:0]       Flags_i,
  input  logic [XLEN-1:0]  ALUResult_i,
  input  logic [XLEN-1:0]  PCTarget_i,
  input  logic [XLEN-1:0]  PCPlus4_i,
  input  logic [XLEN-1:0]  WriteData_i,
  input  logic [4:0]       Rd_i,
  input  logic             RegWrite_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       ResultSrc_i,
  output logic             PCSrc_o,
  output logic [XLEN-1:0]  PCTarget_o,
  output logic             FlushFD_o,
  output logic             MisalignExc_o,
  output logic             ValidM_o,
  output logic [XLEN-1:0]  ALUResultM_o,
  output logic [XLEN-1:0]  WriteDataM_o,
  output logic [XLEN-1:0]  PCPlus4M_o,
  output logic [4:0]       RdM_o,
  output logic             RegWriteM_o,
  output logic             MemWriteM_o,
  output logic [1:0]       ResultSrcM_o,
  output logic [2:0]       Funct3M_o,
  output logic [CNT_W-1:0] BranchCnt_o,
  output logic [CNT_W-1:0] TakenCnt_o
);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  logic flag_zero;
  logic flag_gt;
  logic flag_gtu;
  logic cond;
  logic take;
  logic accept;
  logic misalign;
  logic redirect;
  logic load_bubble;

  assign {flag_zero, flag_gt, flag_gtu} = Flags_i;

  // gt/gtu mean A>=B, so the "less than" branches are their complements.
  always_comb begin
    cond = 1'b0;
    case (Funct3_i)
      F3_BEQ:  cond = flag_zero;
      F3_BNE:  cond = !flag_zero;
      F3_BLT:  cond = !flag_gt;
      F3_BGE:  cond = flag_gt;
      F3_BLTU: cond = !flag_gtu;
      F3_BGEU: cond = flag_gtu;
      default: cond = 1'b0;
    endcase
  end

  // Handshake: an EX instruction moves into EX/MEM only when Valid_i is high and neither
  // Stall_i (hold) nor Flush_i (kill) is asserted; Flush_i wins over Stall_i.
  assign take        = Jump_i | (Branch_i & cond);
  assign accept      = Valid_i & !Stall_i & !Flush_i;
  assign misalign    = take & (PCTarget_i[1:0] != 2'b00);
  assign redirect    = accept & take & !misalign;
  assign load_bubble = Flush_i | (!Stall_i & !Valid_i);

  assign PCSrc_o    = redirect;
  assign FlushFD_o  = redirect;
  assign PCTarget_o = PCTarget_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ValidM_o      <= 1'b0;
      ALUResultM_o  <= '0;
      WriteDataM_o  <= '0;
      PCPlus4M_o    <= '0;
      RdM_o         <= '0;
      RegWriteM_o   <= 1'b0;
      MemWriteM_o   <= 1'b0;
      ResultSrcM_o  <= '0;
      Funct3M_o     <= '0;
      MisalignExc_o <= 1'b0;
    end else if (load_bubble) begin
      ValidM_o      <= 1'b0;
      ALUResultM_o  <= '0;
      WriteDataM_o  <= '0;
      PCPlus4M_o    <= '0;
      RdM_o         <= '0;
      RegWriteM_o   <= 1'b0;
      MemWriteM_o   <= 1'b0;
      ResultSrcM_o  <= '0;
      Funct3M_o     <= '0;
      MisalignExc_o <= 1'b0;
    end else if (accept) begin
      // A misaligned target keeps the instruction valid so the trap can be raised in M,
      // but suppresses its architectural side effects.
      ValidM_o      <= 1'b1;
      ALUResultM_o  <= ALUResult_i;
      WriteDataM_o  <= WriteData_i;
      PCPlus4M_o    <= PCPlus4_i;
      RdM_o         <= Rd_i;
      RegWriteM_o   <= RegWrite_i & !misalign;
      MemWriteM_o   <= MemWrite_i & !misalign;
      ResultSrcM_o  <= ResultSrc_i;
      Funct3M_o     <= Funct3_i;
      MisalignExc_o <= misalign;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      BranchCnt_o <= '0;
      TakenCnt_o  <= '0;
    end else begin
      if (accept & (Branch_i | Jump_i)) BranchCnt_o <= BranchCnt_o + 1'b1;
      if (redirect)                     TakenCnt_o  <= TakenCnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized bench for ex_mem_stage against a rule-level reference model; a second
// instance with 3-bit counters exercises counter wrap-around alongside the main one.
module tb_ex_mem_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
    logic            rw;
    logic            mw;
    logic [1:0]      rs;
    logic [2:0]      f3;
    logic            mexc;
  } m_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid, stall, flush, branch, jump;
  logic [2:0]      funct3, flags;
  logic [XLEN-1:0] alu_result, pc_target, pc_plus4, write_data;
  logic [4:0]      rd;
  logic            reg_write, mem_write;
  logic [1:0]      result_src;

  logic            pc_src, flush_fd, misalign_exc, valid_m, reg_write_m, mem_write_m;
  logic [XLEN-1:0] pc_target_o, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]      rd_m;
  logic [1:0]      result_src_m;
  logic [2:0]      funct3_m;
  logic [31:0]     branch_cnt, taken_cnt;

  logic            w_pc_src, w_flush_fd, w_misalign_exc, w_valid_m, w_reg_write_m, w_mem_write_m;
  logic [XLEN-1:0] w_pc_target_o, w_alu_result_m, w_write_data_m, w_pc_plus4_m;
  logic [4:0]      w_rd_m;
  logic [1:0]      w_result_src_m;
  logic [2:0]      w_funct3_m;
  logic [2:0]      w_branch_cnt, w_taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  m_t          mdl;
  int unsigned mdl_br;
  int unsigned mdl_tk;
  logic [$bits(m_t)-1:0] exp_q[$];

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .Valid_i(valid), .Stall_i(stall), .Flush_i(flush),
    .Branch_i(branch), .Jump_i(jump), .Funct3_i(funct3), .Flags_i(flags),
    .ALUResult_i(alu_result), .PCTarget_i(pc_target), .PCPlus4_i(pc_plus4),
    .WriteData_i(write_data), .Rd_i(rd), .RegWrite_i(reg_write), .MemWrite_i(mem_write),
    .ResultSrc_i(result_src), .PCSrc_o(pc_src), .PCTarget_o(pc_target_o),
    .FlushFD_o(flush_fd), .MisalignExc_o(misalign_exc), .ValidM_o(valid_m),
    .ALUResultM_o(alu_result_m), .WriteDataM_o(write_data_m), .PCPlus4M_o(pc_plus4_m),
    .RdM_o(rd_m), .RegWriteM_o(reg_write_m), .MemWriteM_o(mem_write_m),
    .ResultSrcM_o(result_src_m), .Funct3M_o(funct3_m),
    .BranchCnt_o(branch_cnt), .TakenCnt_o(taken_cnt)
  );

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(3)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .Valid_i(valid), .Stall_i(stall), .Flush_i(flush),
    .Branch_i(branch), .Jump_i(jump), .Funct3_i(funct3), .Flags_i(flags),
    .ALUResult_i(alu_result), .PCTarget_i(pc_target), .PCPlus4_i(pc_plus4),
    .WriteData_i(write_data), .Rd_i(rd), .RegWrite_i(reg_write), .MemWrite_i(mem_write),
    .ResultSrc_i(result_src), .PCSrc_o(w_pc_src), .PCTarget_o(w_pc_target_o),
    .FlushFD_o(w_flush_fd), .MisalignExc_o(w_misalign_exc), .ValidM_o(w_valid_m),
    .ALUResultM_o(w_alu_result_m), .WriteDataM_o(w_write_data_m), .PCPlus4M_o(w_pc_plus4_m),
    .RdM_o(w_rd_m), .RegWriteM_o(w_reg_write_m), .MemWriteM_o(w_mem_write_m),
    .ResultSrcM_o(w_result_src_m), .Funct3M_o(w_funct3_m),
    .BranchCnt_o(w_branch_cnt), .TakenCnt_o(w_taken_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference rules: branch condition table, take/accept/misalign definitions.
  function automatic logic ref_cond(input logic [2:0] f3, input logic [2:0] fl);
    logic z, ge, geu;
    {z, ge, geu} = fl;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return !ge;
      3'd5: return ge;
      3'd6: return !geu;
      3'd7: return geu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_take();
    return jump | (branch & ref_cond(funct3, flags));
  endfunction

  function automatic logic ref_mis();
    return ref_take() && (pc_target % 4 != 0);
  endfunction

  function automatic logic ref_accept();
    return valid && !stall && !flush;
  endfunction

  function automatic logic ref_redirect();
    return ref_accept() && ref_take() && !ref_mis();
  endfunction

  task automatic model_reset();
    mdl    = '0;
    mdl_br = 0;
    mdl_tk = 0;
  endtask

  task automatic model_edge();
    logic mis;
    mis = ref_mis();
    if (ref_accept() && (branch || jump)) mdl_br++;
    if (ref_redirect()) mdl_tk++;
    if (flush || (!stall && !valid)) begin
      mdl = '0;
    end else if (!stall) begin
      mdl.valid = 1'b1;
      mdl.alu   = alu_result;
      mdl.wd    = write_data;
      mdl.pc4   = pc_plus4;
      mdl.rd    = rd;
      mdl.rw    = reg_write && !mis;
      mdl.mw    = mem_write && !mis;
      mdl.rs    = result_src;
      mdl.f3    = funct3;
      mdl.mexc  = mis;
    end
    exp_q.push_back(mdl);
  endtask

  task automatic check_comb();
    check("pcsrc", 64'(pc_src), 64'(ref_redirect()));
    check("flushfd", 64'(flush_fd), 64'(ref_redirect()));
    check("pctarget_o", 64'(pc_target_o), 64'(pc_target));
  endtask

  task automatic check_regs();
    m_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
      return;
    end
    e = m_t'(exp_q.pop_front());
    check("valid_m", 64'(valid_m), 64'(e.valid));
    check("alu_m", 64'(alu_result_m), 64'(e.alu));
    check("wdata_m", 64'(write_data_m), 64'(e.wd));
    check("pc4_m", 64'(pc_plus4_m), 64'(e.pc4));
    check("rd_m", 64'(rd_m), 64'(e.rd));
    check("regwrite_m", 64'(reg_write_m), 64'(e.rw));
    check("memwrite_m", 64'(mem_write_m), 64'(e.mw));
    check("resultsrc_m", 64'(result_src_m), 64'(e.rs));
    check("funct3_m", 64'(funct3_m), 64'(e.f3));
    check("misalign_exc", 64'(misalign_exc), 64'(e.mexc));
    check("branch_cnt", 64'(branch_cnt), 64'(mdl_br));
    check("taken_cnt", 64'(taken_cnt), 64'(mdl_tk));
    check("branch_cnt_w3", 64'(w_branch_cnt), 64'(mdl_br % 8));
    check("taken_cnt_w3", 64'(w_taken_cnt), 64'(mdl_tk % 8));
  endtask

  // One cycle: inputs already driven after a negedge; check comb, clock, check regs.
  task automatic step();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_regs();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic b,
                       input logic j, input logic [2:0] f3, input logic [2:0] fl,
                       input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] pc4,
                       input logic [4:0] d, input logic rw, input logic mw);
    valid = v; stall = s; flush = f; branch = b; jump = j;
    funct3 = f3; flags = fl; pc_target = tgt; pc_plus4 = pc4;
    rd = d; reg_write = rw; mem_write = mw;
    alu_result = $urandom(); write_data = $urandom(); result_src = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_random();
    logic [XLEN-1:0] tgt;
    tgt = $urandom() & ~32'h3;
    if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)), tgt, $urandom(), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_m"}, 64'(valid_m), 64'(0));
    check({tag, "_regwrite_m"}, 64'(reg_write_m), 64'(0));
    check({tag, "_memwrite_m"}, 64'(mem_write_m), 64'(0));
    check({tag, "_alu_m"}, 64'(alu_result_m), 64'(0));
    check({tag, "_rd_m"}, 64'(rd_m), 64'(0));
    check({tag, "_misalign"}, 64'(misalign_exc), 64'(0));
    check({tag, "_branch_cnt"}, 64'(branch_cnt), 64'(0));
    check({tag, "_taken_cnt"}, 64'(taken_cnt), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0);
    model_reset();
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken on zero flag
    drive(1, 0, 0, 1, 0, 3'd0, 3'b100, 32'h100, 32'h8, 5'd0, 0, 0);
    step();
    // Every condition x every flag combination, including never-taken 010/011
    for (int f3 = 0; f3 < 8; f3++)
      for (int fl = 0; fl < 8; fl++) begin
        drive(1, 0, 0, 1, 0, 3'(f3), 3'(fl), 32'h200, 32'h10, 5'd3, 0, 0);
        step();
      end
    // JAL with link write
    drive(1, 0, 0, 0, 1, 3'd0, 3'd0, 32'h40, 32'h24, 5'd1, 1, 0);
    step();
    // Branch and jump together behave as a jump
    drive(1, 0, 0, 1, 1, 3'd2, 3'd0, 32'h80, 32'h28, 5'd2, 1, 0);
    step();
    // Three stalled cycles with fresh inputs, one of them misaligned
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 3'd0, 3'b100, (i == 1) ? 32'h102 : 32'h300, 32'h30, 5'd7, 1, 1);
      step();
    end
    // Stall and flush together
    drive(1, 1, 1, 0, 1, 3'd0, 3'd0, 32'h40, 32'h34, 5'd8, 1, 1);
    step();
    // Taken jump to misaligned target
    drive(1, 0, 0, 0, 1, 3'd0, 3'd0, 32'h102, 32'h38, 5'd9, 1, 1);
    step();

    for (int i = 0; i < 1500; i++) begin
      drive_random();
      step();
    end

    // Asynchronous reset between edges
    drive(1, 0, 0, 0, 1, 3'd0, 3'd0, 32'h40, 32'h44, 5'd4, 1, 1);
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("async_reset");
    valid = 1'b0;
    #1 check("pcsrc_after_valid_drop", 64'(pc_src), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory boundary of the reduced RISC-V core, directly downstream of the ALU.
- Consumes ALUResult and the 3-bit branch flags {zero, gt, gtu} and resolves conditional branches and jumps combinationally.
- Registers the EX/MEM pipeline state, with stall and bubble insertion.
- Keeps branch/taken event counters for bring-up.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of each event counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- Valid_i  in  1  EX holds a real instruction
- Stall_i  in  1  hold EX/MEM register (memory not ready)
- Flush_i  in  1  insert bubble into EX/MEM (trap/kill)
- Branch_i  in  1  EX instruction is a conditional branch
- Jump_i  in  1  EX instruction is JAL/JALR
- Funct3_i  in  3  instruction funct3
- Flags_i  in  3  {zero, gt(signed A>=B), gtu(unsigned A>=B)} from ALU
- ALUResult_i  in  XLEN  ALU result
- PCTarget_i  in  XLEN  computed branch/jump target
- PCPlus4_i  in  XLEN  link value
- WriteData_i  in  XLEN  store data
- Rd_i  in  5  destination register
- RegWrite_i  in  1  writeback enable
- MemWrite_i  in  1  store enable
- ResultSrc_i  in  2  writeback mux select
- PCSrc_o  out  1  redirect fetch to PCTarget_o (combinational)
- PCTarget_o  out  XLEN  pass-through of PCTarget_i
- FlushFD_o  out  1  kill IF/ID and ID/EX (equals PCSrc_o)
- MisalignExc_o  out  1  registered: taken target not 4-byte aligned
- ValidM_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o, RdM_o, RegWriteM_o, MemWriteM_o, ResultSrcM_o, Funct3M_o  out  as inputs  registered EX/MEM state
- BranchCnt_o  out  CNT_W  resolved branches+jumps
- TakenCnt_o  out  CNT_W  taken branches+jumps

Behaviour:
- Reset (rst_n_i low, async): all registered outputs 0; counters 0; MisalignExc_o 0.
- Condition decode by Funct3_i:
  - 000 BEQ: taken = zero
  - 001 BNE: taken = !zero
  - 100 BLT: taken = !gt
  - 101 BGE: taken = gt
  - 110 BLTU: taken = !gtu
  - 111 BGEU: taken = gtu
  - 010/011: never taken
- take = Jump_i | (Branch_i & cond).
- accept = Valid_i & !Stall_i & !Flush_i.
- misalign = take & (PCTarget_i[1:0] != 0).
- PCSrc_o = accept & take & !misalign. Purely combinational, same cycle as EX; FlushFD_o = PCSrc_o.
- EX/MEM register update priority, evaluated each rising edge:
  - Flush_i high: bubble loaded. ValidM_o, RegWriteM_o and MemWriteM_o go to 0; other fields don't-care, implemented as 0. Flush_i overrides Stall_i.
  - Else Stall_i high: all EX/MEM registers hold.
  - Else Valid_i low: bubble loaded.
  - Else all fields load from inputs. If misalign: RegWriteM_o=0, MemWriteM_o=0, ValidM_o=1.
- Latency: EX inputs appear on M outputs one cycle after accept.
- MisalignExc_o:
  - Loads misalign on accept.
  - Clears to 0 on bubble load.
  - Holds on stall.
- Counters, wrapping modulo 2^CNT_W:
  - BranchCnt_o increments on accept & (Branch_i | Jump_i).
  - TakenCnt_o increments on accept & take & !misalign.
- Branch_i and Jump_i both high: treated as jump (always taken).
- Jump writes link: RegWrite_i and ResultSrc_i pass through unchanged on taken jumps; the instruction itself is never killed by its own redirect.
- Reset asserted mid-operation: immediate bubble; PCSrc_o depends only on inputs and drops as soon as Valid_i drops.

Test Plan:
- BEQ, Flags_i=3'b100, Valid_i=1, PCTarget_i=0x100 -> PCSrc_o=1 same cycle; next edge ValidM_o=1, RegWriteM_o=0; TakenCnt_o=1, BranchCnt_o=1.
- BLT/BGE/BLTU/BGEU/BNE with every Flags_i combination (8x6) -> taken per decode table; Funct3 010/011 -> PCSrc_o=0 and BranchCnt_o still increments.
- JAL, RegWrite_i=1, Rd_i=1, PCPlus4_i=0x24, PCTarget_i=0x40 -> PCSrc_o=1; next cycle RdM_o=1, PCPlus4M_o=0x24, RegWriteM_o=1.
- Stall_i=1 for 3 cycles with new inputs presented -> M outputs frozen, PCSrc_o=0, counters unchanged; Stall_i and Flush_i together -> bubble (ValidM_o=0, MemWriteM_o=0).
- Taken jump with PCTarget_i=0x102 -> PCSrc_o=0; MisalignExc_o=1 next cycle with RegWriteM_o=0; TakenCnt_o unchanged.
- Preload counters to 0xFFFFFFFF via a forced state, then accept a taken branch -> both counters wrap to 0. Separately, assert rst_n_i low between clock edges -> all outputs 0 immediately.
